// File: rtl/pwm_shadow_array.sv
// Multi-channel PWM generator sharing one counter, with double-buffered duty/mode
// words that move from shadow to active only at a period boundary.
module pwm_shadow_array #(
    parameter int SysClk     = 125000000,
    parameter int NPWM       = 8,
    parameter int PWMFreq    = 50,
    parameter int Resolution = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 FreqSel,
    input  logic                       Mode,
    input  logic [NPWM*Resolution-1:0] DC_bus,
    input  logic                       DC_load,
    input  logic [NPWM-1:0]            ChEn,
    output logic [NPWM-1:0]            PWMOut,
    output logic                       PeriodStart,
    output logic                       UpdPending
);

    localparam int BASE_DIV = SysClk / (PWMFreq * (32'sd1 <<< Resolution));

    function automatic int calc_div(input int shift);
        int d;
        d = BASE_DIV >>> shift;
        return (d < 32'sd1) ? 32'sd1 : d;
    endfunction

    localparam int DIV0 = calc_div(32'sd0);
    localparam int DIV1 = calc_div(32'sd1);
    localparam int DIV2 = calc_div(32'sd2);
    localparam int DIV3 = calc_div(32'sd3);
    localparam int PW   = (DIV0 < 32'sd2) ? 32'sd1 : $clog2(DIV0);

    localparam logic [Resolution-1:0] CNT_MAX  = {Resolution{1'b1}};
    localparam logic [Resolution-1:0] CNT_ZERO = {Resolution{1'b0}};
    localparam logic [Resolution-1:0] CNT_ONE  = {{(Resolution-1){1'b0}}, 1'b1};

    logic [PW-1:0]                r_presc;
    logic [Resolution-1:0]        r_cnt;
    logic                         r_dir_down;
    logic [NPWM*Resolution-1:0]   r_duty_sh;
    logic [NPWM*Resolution-1:0]   r_duty_act;
    logic                         r_mode_sh;
    logic                         r_mode_act;
    logic                         r_pend;
    logic                         r_pstart;
    logic [NPWM-1:0]              r_out;

    logic [PW-1:0]                w_div_m1;
    logic                         w_tick;
    logic [Resolution-1:0]        w_cnt_nxt;
    logic                         w_dir_nxt;
    logic                         w_boundary;

    // Terminal prescaler value for the selected frequency multiplier.
    always_comb begin
        case (FreqSel)
            2'd0:    w_div_m1 = PW'(DIV0 - 32'sd1);
            2'd1:    w_div_m1 = PW'(DIV1 - 32'sd1);
            2'd2:    w_div_m1 = PW'(DIV2 - 32'sd1);
            2'd3:    w_div_m1 = PW'(DIV3 - 32'sd1);
            default: w_div_m1 = PW'(DIV0 - 32'sd1);
        endcase
    end

    // ">=" catches a prescaler left above the new terminal when FreqSel rises.
    assign w_tick = (r_presc >= w_div_m1);

    // Next counter value and direction; edge mode wraps, center mode bounces.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir_down;
        if (w_tick) begin
            if (!r_mode_act) begin
                w_dir_nxt = 1'b0;
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end else if (!r_dir_down) begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt = CNT_MAX - CNT_ONE;
                    w_dir_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    w_dir_nxt = 1'b0;
                end
            end else begin
                if (r_cnt == CNT_ONE) begin
                    w_cnt_nxt = CNT_ZERO;
                    w_dir_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    w_dir_nxt = 1'b1;
                end
            end
        end else begin
            w_cnt_nxt = r_cnt;
            w_dir_nxt = r_dir_down;
        end
    end

    assign w_boundary = w_tick && (w_cnt_nxt == CNT_ZERO);

    // Prescaler, shared counter and boundary pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= {PW{1'b0}};
            r_cnt      <= CNT_ZERO;
            r_dir_down <= 1'b0;
            r_pstart   <= 1'b0;
        end else begin
            r_presc    <= w_tick ? {PW{1'b0}} : (r_presc + {{(PW-1){1'b0}}, 1'b1});
            r_cnt      <= w_cnt_nxt;
            r_dir_down <= w_dir_nxt;
            r_pstart   <= w_boundary;
        end
    end

    // Shadow capture and boundary transfer; a load on the transfer clock
    // hands over the old shadow and keeps the new words pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty_sh  <= {(NPWM*Resolution){1'b0}};
            r_duty_act <= {(NPWM*Resolution){1'b0}};
            r_mode_sh  <= 1'b0;
            r_mode_act <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            if (w_boundary && r_pend) begin
                r_duty_act <= r_duty_sh;
                r_mode_act <= r_mode_sh;
            end
            if (DC_load) begin
                r_duty_sh <= DC_bus;
                r_mode_sh <= Mode;
                r_pend    <= 1'b1;
            end else if (w_boundary) begin
                r_pend    <= 1'b0;
            end else begin
                r_pend    <= r_pend;
            end
        end
    end

    // Per-channel compare against the shared counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= {NPWM{1'b0}};
        end else begin
            for (int i = 0; i < NPWM; i++) begin
                r_out[i] <= ChEn[i] & (r_duty_act[i*Resolution +: Resolution] > r_cnt);
            end
        end
    end

    assign PWMOut      = r_out;
    assign PeriodStart = r_pstart;
    assign UpdPending  = r_pend;

endmodule
